regbank_client: RTL and testbench

Operand-fetch/write-back controller that acts as the initiator toward the core's dual-port register bank. The datapath issues two-operand read requests and single-register write-back requests through valid/ready handshakes. The block sequences the bank's enable_write/enable_read controls, and samples the bank's registered read data only in the cycle it is valid. It enforces register-0-reads-as-zero semantics and hands operands back with an output handshake.

---
 rtl/regbank_client.sv | 146 ++++++++++++++
 tb/tb_regbank_client.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_client.sv
// regbank_client
//   Operand-fetch / write-back controller that drives a dual-port register
//   bank with registered read data. Write-back requests take priority over
//   operand reads; register 0 is never written and always reads as zero.
//
// Ports
//   clock, reset            : single clock, asynchronous active-high reset
//   rd_valid/rd_ready       : operand read request handshake (rd_rs, rd_rt)
//   wb_valid/wb_ready       : write-back request handshake (wb_addr, wb_data)
//   op_valid/op_ready       : operand response handshake (op_a, op_b)
//   bank_address/_addressB  : bank port A / port B addresses
//   bank_enable_write/_read : bank controls, never high together
//   bank_in_data/_dataB     : bank write data (both ports carry the same data)
//   bank_out_data/_dataB    : bank read data, valid the cycle after a read
module regbank_client #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_rs,
  input  logic [ADDR_W-1:0] rd_rt,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] bank_address,
  output logic [ADDR_W-1:0] bank_addressB,
  output logic              bank_enable_write,
  output logic              bank_enable_read,
  output logic [DATA_W-1:0] bank_in_data,
  output logic [DATA_W-1:0] bank_in_dataB,
  input  logic [DATA_W-1:0] bank_out_data,
  input  logic [DATA_W-1:0] bank_out_dataB
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  // Latched request: port A/B addresses double as the bank address outputs,
  // so they naturally hold their last value outside WRITE/READ.
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred. Blocking
  // assignments are correct in combinational logic.
  always_comb begin
    state_d           = state_q;
    addr_a_d          = addr_a_q;
    addr_b_d          = addr_b_q;
    wdata_d           = wdata_q;
    op_a_d            = op_a_q;
    op_b_d            = op_b_q;
    wb_ready          = 1'b0;
    rd_ready          = 1'b0;
    op_valid          = 1'b0;
    bank_enable_write = 1'b0;
    bank_enable_read  = 1'b0;

    case (state_q)
      S_IDLE: begin
        wb_ready = 1'b1;
        // A pending write-back masks the read handshake this cycle.
        rd_ready = ~wb_valid;
        if (wb_valid) begin
          addr_a_d = wb_addr;
          addr_b_d = wb_addr;
          wdata_d  = wb_data;
          state_d  = S_WRITE;
        end else if (rd_valid) begin
          addr_a_d = rd_rs;
          addr_b_d = rd_rt;
          state_d  = S_READ;
        end
      end
      S_WRITE: begin
        // Register 0 is hard-wired to zero: the cycle is spent but the bank
        // is left untouched.
        bank_enable_write = (addr_a_q != '0);
        state_d           = S_IDLE;
      end
      S_READ: begin
        bank_enable_read = 1'b1;
        state_d          = S_CAPTURE;
      end
      S_CAPTURE: begin
        // Bank data registered at the end of READ is valid only here; the
        // previous cycle was a non-write cycle so the bank is not tri-stated.
        op_a_d  = (addr_a_q == '0) ? '0 : bank_out_data;
        op_b_d  = (addr_b_q == '0) ? '0 : bank_out_dataB;
        state_d = S_RESP;
      end
      S_RESP: begin
        op_valid = 1'b1;
        if (op_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_a_q <= '0;
      addr_b_q <= '0;
      wdata_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      wdata_q  <= wdata_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
    end
  end

  // Bank outputs come straight from registers; the bank has no single-port
  // write, so both data ports always carry the same latched write data.
  assign bank_address  = addr_a_q;
  assign bank_addressB = addr_b_q;
  assign bank_in_data  = wdata_q;
  assign bank_in_dataB = wdata_q;
  assign op_a          = op_a_q;
  assign op_b          = op_b_q;

endmodule

// File: tb/tb_regbank_client.sv
// tb_regbank_client
//   Self-checking bench for regbank_client. Contains a dual-port bank model
//   with registered reads, a transaction-level reference model (register
//   array plus accept/response timing), directed scenarios and a randomized
//   phase. Inputs change at posedge+2, outputs are compared at the negedge.
`timescale 1ns/1ps
module tb_regbank_client;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [DW-1:0] POISON = 32'hBAD0_BAD0;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rd_valid = 1'b0, wb_valid = 1'b0, op_ready = 1'b0;
  logic [AW-1:0] rd_rs = '0, rd_rt = '0, wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          rd_ready, wb_ready, op_valid;
  logic [DW-1:0] op_a, op_b;
  logic [AW-1:0] bank_address, bank_addressB;
  logic          bank_enable_write, bank_enable_read;
  logic [DW-1:0] bank_in_data, bank_in_dataB;
  logic [DW-1:0] bank_out_data, bank_out_dataB;

  regbank_client #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_rs(rd_rs), .rd_rt(rd_rt),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .bank_address(bank_address), .bank_addressB(bank_addressB),
    .bank_enable_write(bank_enable_write), .bank_enable_read(bank_enable_read),
    .bank_in_data(bank_in_data), .bank_in_dataB(bank_in_dataB),
    .bank_out_data(bank_out_data), .bank_out_dataB(bank_out_dataB)
  );

  initial forever #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 0) ? 32'hAAAA_AAAA : (32'hC0DE_0000 | 32'(i));
  endfunction

  // ---------------- bank model: registered read, write on both ports -------
  logic [DW-1:0] mem [32];
  logic [DW-1:0] bq_a = '0, bq_b = '0;
  // POISON stands in for the bank's high-impedance output during writes.
  assign bank_out_data  = bank_enable_write ? POISON : bq_a;
  assign bank_out_dataB = bank_enable_write ? POISON : bq_b;

  initial begin : bank_model
    logic          s_we, s_re;
    logic [AW-1:0] s_aa, s_ab;
    logic [DW-1:0] s_da, s_db;
    for (int i = 0; i < 32; i++) mem[i] = init_val(i);
    forever begin
      @(negedge clock);
      s_we = bank_enable_write; s_re = bank_enable_read;
      s_aa = bank_address;      s_ab = bank_addressB;
      s_da = bank_in_data;      s_db = bank_in_dataB;
      @(posedge clock);
      if (!reset) begin
        if (s_re) begin bq_a <= mem[s_aa]; bq_b <= mem[s_ab]; end
        if (s_we) begin mem[s_aa] <= s_da; mem[s_ab] <= s_db; end
      end
    end
  end

  // ---------------- bank outputs must not follow request inputs ------------
  logic [75:0] bank_bus;
  assign bank_bus = {bank_address, bank_addressB, bank_enable_write, bank_enable_read,
                     bank_in_data, bank_in_dataB};

  initial begin : comb_path_monitor
    logic [75:0] snap;
    forever begin
      @(posedge clock);
      #1 snap = bank_bus;
      #2 if (!reset) check("bank_no_comb_path", bank_bus, snap);
    end
  end

  // ---------------- transaction-level reference model ----------------------
  logic [DW-1:0] ref_regs [32];
  int            m_cyc = 0, m_idle_from = 0, m_valid_from = 0;
  int            m_wr_cyc = -1, m_rd_cyc = -1;
  bit            m_pend = 0;
  logic [AW-1:0] m_wa, m_rs, m_rt;
  logic [DW-1:0] m_wd, m_ea, m_eb;

  initial begin : ref_model
    bit e_idle, e_valid;
    for (int i = 0; i < 32; i++) ref_regs[i] = init_val(i);
    forever begin
      @(negedge clock);
      if (reset) begin
        m_pend = 0; m_idle_from = m_cyc; m_wr_cyc = -1; m_rd_cyc = -1;
      end else begin
        e_idle  = !m_pend && (m_cyc >= m_idle_from);
        e_valid = m_pend && (m_cyc >= m_valid_from);
        check("wb_ready", wb_ready, e_idle);
        check("rd_ready", rd_ready, e_idle && !wb_valid);
        check("op_valid", op_valid, e_valid);
        if (e_valid) begin
          check("op_a", op_a, m_ea);
          check("op_b", op_b, m_eb);
        end
        check("bank_we", bank_enable_write, (m_cyc == m_wr_cyc) && (m_wa != 0));
        check("bank_re", bank_enable_read, m_cyc == m_rd_cyc);
        check("bank_en_excl", bank_enable_write & bank_enable_read, 1'b0);
        if (m_cyc == m_wr_cyc) begin
          check("wr_addr", {bank_address, bank_addressB}, {m_wa, m_wa});
          check("wr_data", {bank_in_data, bank_in_dataB}, {m_wd, m_wd});
          // The write lands at the coming edge unless reset intervenes first.
          if (m_wa != 0) ref_regs[m_wa] = m_wd;
        end
        if (m_cyc == m_rd_cyc)
          check("rd_addr", {bank_address, bank_addressB}, {m_rs, m_rt});
        if (e_idle && wb_valid) begin
          m_wa = wb_addr; m_wd = wb_data;
          m_wr_cyc = m_cyc + 1; m_idle_from = m_cyc + 2;
        end else if (e_idle && rd_valid) begin
          m_rs = rd_rs; m_rt = rd_rt;
          m_ea = (rd_rs == 0) ? '0 : ref_regs[rd_rs];
          m_eb = (rd_rt == 0) ? '0 : ref_regs[rd_rt];
          m_rd_cyc = m_cyc + 1; m_valid_from = m_cyc + 3; m_pend = 1;
        end
        if (e_valid && op_ready) begin
          m_pend = 0; m_idle_from = m_cyc + 1;
        end
      end
      m_cyc++;
    end
  end

  // ---------------- driver tasks (entered and left at posedge+2) -----------
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = 1'b1; wb_addr = a; wb_data = d;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (wb_ready) break;
    end
    if (!wb_ready) check("wb_accept_timeout", wb_ready, 1'b1);
    @(posedge clock); #2;
    wb_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] rs, input logic [AW-1:0] rt);
    rd_valid = 1'b1; rd_rs = rs; rd_rt = rt;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (rd_ready) break;
    end
    if (!rd_ready) check("rd_accept_timeout", rd_ready, 1'b1);
    @(posedge clock); #2;
    rd_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [DW-1:0] a, output logic [DW-1:0] b, output int lat);
    op_ready = 1'b1; lat = 0; a = '0; b = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      lat++;
      if (op_valid) break;
    end
    if (!op_valid) check("resp_timeout", op_valid, 1'b1);
    else begin a = op_a; b = op_b; end
    @(posedge clock); #2;
    op_ready = 1'b0;
  endtask

  // ---------------- directed scenarios, random phase, summary --------------
  initial begin : main
    logic [DW-1:0] a, b, a0, b0;
    int lat;

    #3;
    check("rst_rd_ready", rd_ready, 1'b1);
    check("rst_wb_ready", wb_ready, 1'b1);
    check("rst_op_valid", op_valid, 1'b0);
    check("rst_ops", {op_a, op_b}, 64'h0);
    check("rst_bank", bank_bus, 76'h0);
    #9 reset = 1'b0;
    @(posedge clock); #2;

    // Write then read back on both ports.
    do_write(5'd5, 32'hDEAD_BEEF);
    do_read(5'd5, 5'd5);
    wait_resp(a, b, lat);
    check("t1_op_a", a, 32'hDEAD_BEEF);
    check("t1_op_b", b, 32'hDEAD_BEEF);
    check("t1_latency", lat, 3);

    // Simultaneous write-back and read: write wins, read follows.
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234_5678;
    rd_valid = 1'b1; rd_rs = 5'd7; rd_rt = 5'd0;
    @(negedge clock);
    check("t2_rd_blocked", rd_ready, 1'b0);
    check("t2_wb_ready", wb_ready, 1'b1);
    @(posedge clock); #2;
    wb_valid = 1'b0;
    do_read(5'd7, 5'd0);
    wait_resp(a, b, lat);
    check("t2_op_a", a, 32'h1234_5678);
    check("t2_op_b", b, 32'h0);

    // Register 0: write suppressed, read forced to zero despite bank content.
    do_write(5'd0, 32'hFFFF_FFFF);
    @(negedge clock);
    check("t3_no_we_r0", bank_enable_write, 1'b0);
    @(posedge clock); #2;
    do_read(5'd0, 5'd5);
    wait_resp(a, b, lat);
    check("t3_op_a_r0", a, 32'h0);
    check("t3_op_b", b, 32'hDEAD_BEEF);

    // Back-pressure for 10 cycles with another read waiting.
    op_ready = 1'b0;
    do_read(5'd5, 5'd7);
    rd_valid = 1'b1; rd_rs = 5'd1; rd_rt = 5'd2;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (op_valid) break;
    end
    if (!op_valid) check("t4_valid_timeout", op_valid, 1'b1);
    a0 = op_a; b0 = op_b;
    check("t4_op_a", a0, 32'hDEAD_BEEF);
    check("t4_op_b", b0, 32'h1234_5678);
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      check("t4_hold_valid", op_valid, 1'b1);
      check("t4_hold_ops", {op_a, op_b}, {a0, b0});
      check("t4_hold_rd_ready", rd_ready, 1'b0);
    end
    @(posedge clock); #2;
    op_ready = 1'b1; rd_valid = 1'b0;
    @(negedge clock);
    check("t4_xfer_valid", op_valid, 1'b1);
    @(posedge clock); #2;
    op_ready = 1'b0;
    @(negedge clock);
    check("t4_after_valid", op_valid, 1'b0);
    check("t4_after_idle", {wb_ready, rd_ready}, 2'b11);
    @(posedge clock); #2;

    // Reset during CAPTURE.
    do_read(5'd5, 5'd5);
    @(posedge clock); #4;
    reset = 1'b1;
    #1;
    check("t5_op_valid", op_valid, 1'b0);
    check("t5_enables", {bank_enable_write, bank_enable_read}, 2'b00);
    #2 reset = 1'b0;
    @(posedge clock); #2;
    check("t5_ready_after", {rd_ready, wb_ready}, 2'b11);

    // Reset during RESP: op_valid drops without a clock edge.
    op_ready = 1'b0;
    do_read(5'd7, 5'd7);
    @(posedge clock);
    @(posedge clock); #1;
    check("t6_valid_before", op_valid, 1'b1);
    #3 reset = 1'b1;
    #1;
    check("t6_op_valid", op_valid, 1'b0);
    check("t6_op_a", op_a, 32'h0);
    #2 reset = 1'b0;
    @(posedge clock); #2;

    // Reset during WRITE: enable drops and the register keeps its old value.
    do_write(5'd9, 32'h0BAD_F00D);
    #1 check("t7_we_before", bank_enable_write, 1'b1);
    #1 reset = 1'b1;
    #1 check("t7_we_after", bank_enable_write, 1'b0);
    #2 reset = 1'b0;
    @(posedge clock); #2;
    do_read(5'd9, 5'd0);
    wait_resp(a, b, lat);
    check("t7_r9_unchanged", a, 32'hC0DE_0009);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #2;
      wb_valid = ($urandom_range(0, 3) == 0);
      wb_addr  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      wb_data  = $urandom;
      rd_valid = ($urandom_range(0, 1) == 1);
      rd_rs    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      rd_rt    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      op_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clock); #2;
    wb_valid = 1'b0; rd_valid = 1'b0; op_ready = 1'b1;
    repeat (10) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
